// File: rtl/pipe_shifter.sv
// pipe_shifter: two-stage valid/ready shifter unit (LSL, LSR, ASR, optional ROL/ROR).
// Define PIPE_SHIFTER_ROTATE_EN to build the rotate datapath; without it op 011
// behaves as LSL and op 100 behaves as LSR.
module pipe_shifter #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [AW-1:0]    B,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [AW-1:0]    s1_b_q, s1_b_d;

  // Stage 2: result and flags
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             adv;
  logic             in_fire;

  assign adv      = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || adv;
  assign in_fire  = in_valid && in_ready;

  // Extended shifts: the extra bit holds the last bit shifted out (0 when B=0).
  logic [WIDTH:0]   lsl_ext;
  logic [WIDTH:0]   lsr_ext;
  logic [WIDTH:0]   asr_ext;
  logic [WIDTH-1:0] keep_mask;

  assign lsl_ext   = {1'b0, s1_a_q} << s1_b_q;
  assign lsr_ext   = {s1_a_q, 1'b0} >> s1_b_q;
  assign asr_ext   = $unsigned($signed({s1_a_q, 1'b0}) >>> s1_b_q);
  assign keep_mask = {WIDTH{1'b1}} >> s1_b_q;

`ifdef PIPE_SHIFTER_ROTATE_EN
  logic [AW-2:0]    rot_amt;
  logic [AW-1:0]    rot_inv;
  logic [WIDTH-1:0] rol_res;
  logic [WIDTH-1:0] ror_res;

  assign rot_amt = s1_b_q[AW-2:0];
  assign rot_inv = AW'(WIDTH) - {1'b0, rot_amt};
  assign rol_res = (s1_a_q << rot_amt) | (s1_a_q >> rot_inv);
  assign ror_res = (s1_a_q >> rot_amt) | (s1_a_q << rot_inv);
`endif

  logic [2:0]       op_eff;
  logic [WIDTH-1:0] res_out;
  logic             res_carry;
  logic             res_ovf;
  logic             res_zero;

  // Opcode remap: rotate codes fall back to plain shifts when rotates are absent
  always_comb begin
    op_eff = s1_op_q;
`ifndef PIPE_SHIFTER_ROTATE_EN
    if (s1_op_q == OP_ROL) begin
      op_eff = OP_LSL;
    end else if (s1_op_q == OP_ROR) begin
      op_eff = OP_LSR;
    end
`endif
  end

  // Result and flag computation for the operation held in stage 1
  always_comb begin
    res_out   = s1_a_q;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (op_eff)
      OP_LSL: begin
        res_out   = lsl_ext[WIDTH-1:0];
        res_carry = lsl_ext[WIDTH];
        res_ovf   = |(s1_a_q & ~keep_mask);
      end
      OP_LSR: begin
        res_out   = lsr_ext[WIDTH:1];
        res_carry = lsr_ext[0];
      end
      OP_ASR: begin
        res_out   = asr_ext[WIDTH:1];
        res_carry = asr_ext[0];
      end
`ifdef PIPE_SHIFTER_ROTATE_EN
      OP_ROL: begin
        res_out   = rol_res;
        res_carry = (rot_amt != '0) && rol_res[0];
      end
      OP_ROR: begin
        res_out   = ror_res;
        res_carry = (rot_amt != '0) && ror_res[WIDTH-1];
      end
`endif
      default: begin
        res_out   = s1_a_q;
      end
    endcase
    res_zero = (res_out == '0);
  end

  // Next-state for both pipeline stages
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op;
      s1_a_d     = A;
      s1_b_d     = B;
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end

    if (adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d   = res_out;
        carry_d = res_carry;
        ovf_d   = res_ovf;
        zero_d  = res_zero;
      end
    end
  end

  // Pipeline registers; reset drops any in-flight work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: scoreboard bench for pipe_shifter at WIDTH=16.
// Honours PIPE_SHIFTER_ROTATE_EN the same way as the design.
module tb_pipe_shifter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [AW-1:0]    B = '0;
  logic [2:0]       op = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             ovf;
  logic             zero;

  pipe_shifter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry(carry), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             ovf;
    logic             zero;
  } res_t;

  typedef struct {
    logic [2:0]    op;
    logic [15:0]   a;
    logic [AW-1:0] b;
    res_t          e;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  bit   rand_done;

  // Bit-serial reference: shift or rotate one position at a time
  function automatic res_t model(input logic [2:0] o, input logic [15:0] a, input logic [AW-1:0] b);
    res_t       r;
    logic [2:0] eo;
    logic [15:0] v;
    logic       c;
    logic       f;
    int         n;
    v = a; c = 1'b0; f = 1'b0; eo = o;
`ifndef PIPE_SHIFTER_ROTATE_EN
    if (o == 3'b011) eo = 3'b000;
    if (o == 3'b100) eo = 3'b001;
`endif
    case (eo)
      3'b000: for (int i = 0; i < int'(b); i++) begin c = v[15]; f = f | c; v = {v[14:0], 1'b0}; end
      3'b001: for (int i = 0; i < int'(b); i++) begin c = v[0]; v = {1'b0, v[15:1]}; end
      3'b010: for (int i = 0; i < int'(b); i++) begin c = v[0]; v = {v[15], v[15:1]}; end
      3'b011: begin
        n = int'(b) % 16;
        for (int i = 0; i < n; i++) v = {v[14:0], v[15]};
        c = (n != 0) ? v[0] : 1'b0;
      end
      3'b100: begin
        n = int'(b) % 16;
        for (int i = 0; i < n; i++) v = {v[0], v[15:1]};
        c = (n != 0) ? v[15] : 1'b0;
      end
      default: v = a;
    endcase
    r.out = v; r.carry = c; r.ovf = f; r.zero = (v == 16'h0);
    return r;
  endfunction

  function automatic void add_vec(input logic [2:0] o, input logic [15:0] a, input logic [AW-1:0] b,
                                  input logic [15:0] eo, input logic ec, input logic ev, input logic ez);
    vec_t v;
    v.op = o; v.a = a; v.b = b;
    v.e.out = eo; v.e.carry = ec; v.e.ovf = ev; v.e.zero = ez;
    vecs.push_back(v);
  endfunction

  // Offer one operation; push its expected result on the accepting edge
  task automatic send(input logic [2:0] o, input logic [15:0] a, input logic [AW-1:0] b, input res_t e);
    bit acc;
    bit ok;
    ok = 1'b0;
    op = o; A = a; B = b; in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && !ok; cyc++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        exp_q.push_back(e);
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: op=%b A=%h B=%0d never accepted, want accept within 60 cycles", o, a, b);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 16'h0 || carry !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h c=%b v=%b z=%b, want 1 0 0000 0 0 0",
               in_ready, out_valid, out, carry, ovf, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    res_t e;
    vecs.delete();
    add_vec(3'b000, 16'h8001, 5'd1,  16'h0002, 1'b1, 1'b1, 1'b0);
    add_vec(3'b010, 16'h8000, 5'd15, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    add_vec(3'b010, 16'h8000, 5'd16, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    add_vec(3'b001, 16'h8000, 5'd16, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef PIPE_SHIFTER_ROTATE_EN
    add_vec(3'b100, 16'h0001, 5'd4,  16'h1000, 1'b0, 1'b0, 1'b0);
    add_vec(3'b011, 16'h8000, 5'd17, 16'h0001, 1'b1, 1'b0, 1'b0);
    add_vec(3'b011, 16'h1234, 5'd16, 16'h1234, 1'b0, 1'b0, 1'b0);
`else
    add_vec(3'b100, 16'h0001, 5'd4,  16'h0000, 1'b0, 1'b0, 1'b1);
    add_vec(3'b011, 16'h8000, 5'd17, 16'h0000, 1'b0, 1'b1, 1'b1);
    add_vec(3'b011, 16'h1234, 5'd16, 16'h0000, 1'b0, 1'b1, 1'b1);
`endif
    for (int o = 0; o < 8; o++) add_vec(3'(o), 16'hA5A5, 5'd0, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    add_vec(3'b000, 16'h00FF, 5'd8,  16'hFF00, 1'b0, 1'b0, 1'b0);
    add_vec(3'b000, 16'h0100, 5'd8,  16'h0000, 1'b1, 1'b1, 1'b1);
    add_vec(3'b000, 16'h0001, 5'd16, 16'h0000, 1'b1, 1'b1, 1'b1);
    add_vec(3'b001, 16'hFFFF, 5'd31, 16'h0000, 1'b0, 1'b0, 1'b1);
    add_vec(3'b010, 16'h7FFF, 5'd20, 16'h0000, 1'b0, 1'b0, 1'b1);
    add_vec(3'b101, 16'h1234, 5'd3,  16'h1234, 1'b0, 1'b0, 1'b0);
    add_vec(3'b111, 16'h0000, 5'd9,  16'h0000, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL latency_early[%0d]: out_valid=%b one cycle after accept, want 0", i, out_valid);
      end
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL vector[%0d]: nothing expected, out_valid=%b", i, out_valid);
      end else begin
        e = exp_q.pop_front();
        if (out_valid !== 1'b1 || {out, carry, ovf, zero} !== e) begin
          bad++;
          $display("FAIL vector[%0d] op=%b A=%h B=%0d: got v=%b out=%h c=%b o=%b z=%b, want v=1 out=%h c=%b o=%b z=%b",
                   i, vecs[i].op, vecs[i].a, vecs[i].b, out_valid, out, carry, ovf, zero,
                   e.out, e.carry, e.ovf, e.zero);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    vec_t sv[3];
    res_t e;
    int   idx;
    bit   acc;
    sv[0].op = 3'b000; sv[0].a = 16'h0003; sv[0].b = 5'd2; sv[0].e = {16'h000C, 1'b0, 1'b0, 1'b0};
    sv[1].op = 3'b001; sv[1].a = 16'hF000; sv[1].b = 5'd4; sv[1].e = {16'h0F00, 1'b0, 1'b0, 1'b0};
    sv[2].op = 3'b010; sv[2].a = 16'h8000; sv[2].b = 5'd1; sv[2].e = {16'hC000, 1'b0, 1'b0, 1'b0};
    exp_q.delete();
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      op = sv[(idx < 3) ? idx : 2].op; A = sv[(idx < 3) ? idx : 2].a; B = sv[(idx < 3) ? idx : 2].b;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc && idx < 3) begin
        exp_q.push_back(sv[idx].e);
        idx++;
      end
    end
    total++;
    if (idx != 2 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_accept: accepted=%0d in_ready=%b, want 2 and 0", idx, in_ready);
    end
    total++;
    if (out_valid !== 1'b1 || out !== 16'h000C || carry !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL stall_hold: v=%b out=%h c=%b o=%b z=%b, want 1 000c 0 0 0", out_valid, out, carry, ovf, zero);
    end
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      if (r == 0) acc = in_ready;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stall_drain[%0d]: nothing expected, out_valid=%b", r, out_valid);
      end else begin
        e = exp_q.pop_front();
        if (out_valid !== 1'b1 || {out, carry, ovf, zero} !== e) begin
          bad++;
          $display("FAIL stall_drain[%0d]: got v=%b out=%h c=%b o=%b z=%b, want v=1 out=%h c=%b o=%b z=%b",
                   r, out_valid, out, carry, ovf, zero, e.out, e.carry, e.ovf, e.zero);
        end
      end
      @(posedge clk); #1;
      if (r == 0) begin
        if (acc && idx == 2) exp_q.push_back(sv[2].e);
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 10;
    exp_q.delete();
    out_ready = 1'b1;
    fork
      begin
        logic [2:0]  o;
        logic [15:0] a;
        logic [AW-1:0] b;
        for (int i = 0; i < N; i++) begin
          o = 3'($urandom_range(0, 4)); a = 16'($urandom); b = AW'($urandom_range(0, 31));
          send(o, a, b, model(o, a, b));
        end
      end
      begin
        res_t e;
        int   w;
        for (int k = 0; k < N; k++) begin
          w = 0;
          @(negedge clk);
          while (!out_valid && w < 40) begin @(negedge clk); w++; end
          total++;
          if (out_valid !== 1'b1 || exp_q.size() == 0 || (k > 0 && w != 0)) begin
            bad++;
            $display("FAIL b2b[%0d]: out_valid=%b gap=%0d queued=%0d, want valid with no gap", k, out_valid, w, exp_q.size());
          end else begin
            e = exp_q.pop_front();
            if ({out, carry, ovf, zero} !== e) begin
              bad++;
              $display("FAIL b2b[%0d]: got out=%h c=%b o=%b z=%b, want out=%h c=%b o=%b z=%b",
                       k, out, carry, ovf, zero, e.out, e.carry, e.ovf, e.zero);
            end
          end
        end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    localparam int N = 60;
    exp_q.delete();
    rand_done = 1'b0;
    fork
      begin
        logic [2:0]  o;
        logic [15:0] a;
        logic [AW-1:0] b;
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          o = 3'($urandom_range(0, 7)); a = 16'($urandom); b = AW'($urandom_range(0, 31));
          if ($urandom_range(0, 4) == 0) a = 16'h8000 >> $urandom_range(0, 15);
          send(o, a, b, model(o, a, b));
        end
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          if (!rand_done) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        res_t e;
        res_t held;
        bit   hold_pending;
        int   got;
        int   guard;
        got = 0; guard = 0; hold_pending = 1'b0;
        while (got < N && guard < 3000) begin
          @(negedge clk);
          guard++;
          if (hold_pending) begin
            total++;
            if (out_valid !== 1'b1 || {out, carry, ovf, zero} !== held) begin
              bad++;
              $display("FAIL rand_hold: got v=%b out=%h c=%b o=%b z=%b, want v=1 out=%h c=%b o=%b z=%b",
                       out_valid, out, carry, ovf, zero, held.out, held.carry, held.ovf, held.zero);
            end
          end
          hold_pending = 1'b0;
          if (out_valid === 1'b1 && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL rand_extra: unexpected result out=%h", out);
            end else begin
              e = exp_q.pop_front();
              if ({out, carry, ovf, zero} !== e) begin
                bad++;
                $display("FAIL rand[%0d]: got out=%h c=%b o=%b z=%b, want out=%h c=%b o=%b z=%b",
                         got, out, carry, ovf, zero, e.out, e.carry, e.ovf, e.zero);
              end
            end
            got++;
          end else if (out_valid === 1'b1) begin
            held = {out, carry, ovf, zero};
            hold_pending = 1'b1;
          end
        end
        total++;
        if (got != N) begin
          bad++;
          $display("FAIL rand_count: received %0d results, want %0d", got, N);
        end
        rand_done = 1'b1;
      end
    join
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int stale;
    res_t e;
    exp_q.delete();
    out_ready = 1'b0;
    send(3'b000, 16'h0001, 5'd1, model(3'b000, 16'h0001, 5'd1));
    send(3'b001, 16'h8000, 5'd3, model(3'b001, 16'h8000, 5'd3));
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out !== 16'h0 || carry !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_clear: v=%b out=%h c=%b o=%b z=%b in_ready=%b, want 0 0000 0 0 0 1",
               out_valid, out, carry, ovf, zero, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL midreset_stale: out_valid seen %0d cycles after release, want 0", stale);
    end
    @(posedge clk); #1;
    send(3'b001, 16'h00F0, 5'd4, {16'h000F, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL midreset_after: nothing expected, out_valid=%b", out_valid);
    end else begin
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || {out, carry, ovf, zero} !== e) begin
        bad++;
        $display("FAIL midreset_after: got v=%b out=%h c=%b o=%b z=%b, want v=1 out=%h c=%b o=%b z=%b",
                 out_valid, out, carry, ovf, zero, e.out, e.carry, e.ovf, e.zero);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
